lsu: RTL and testbench
======================

// Module: lsu
// PURPOSE
//  Load/store unit: producer of the dm operand that writeback selects with WB_DM.
//  Accepts one memory op from execute and runs a valid/ready request to data memory.
//  For loads it waits for the response, then aligns and sign/zero-extends the data.
//  Stalls the core (busy) for the whole transaction; flags misaligned and timed-out ops.
// PARAMETERS
//  TIMEOUT_CYCLES  16  cycles in REQ+WAIT before abort with bus_error (>=2)
// PORTS
//  clk            in   1   core clock, all state on rising edge
//  reset          in   1   asynchronous, active-low reset
//  req_valid      in   1   execute presents a memory op this cycle
//  req_we         in   1   1=store, 0=load
//  req_width      in   mem_width_t  MEM_BYTE / MEM_HALF / MEM_WORD
//  req_sign_ext   in   1   loads: 1=sign-extend, 0=zero-extend
//  req_addr       in   32  byte address (word)
//  req_wdata      in   32  store data, LSBs significant
//  busy           out  1   stall request to core, = (state != IDLE)
//  rsp_valid      out  1   1-cycle pulse: load data ready on rsp_data / store done
//  rsp_data       out  32  aligned load result -> wb_mux dm input
//  misaligned     out  1   1-cycle pulse: op rejected, no bus access
//  bus_error      out  1   1-cycle pulse: op aborted on timeout
//  mem_req_valid  out  1   bus request
//  mem_req_ready  in   1   memory accepts request
//  mem_we         out  1   bus write enable
//  mem_addr       out  32  word-aligned address {req_addr[31:2],2'b00}
//  mem_be         out  4   byte enables
//  mem_wdata      out  32  replicated store data
//  mem_rsp_valid  in   1   read data valid
//  mem_rsp_rdata  in   32  read data word
// BEHAVIOUR
//  Reset: state IDLE; busy, rsp_valid, misaligned, bus_error, mem_req_valid,
//   mem_we = 0; mem_addr, mem_be, mem_wdata, rsp_data = 0; timeout counter = 0.
//   Reset mid-transaction aborts it immediately; no rsp_valid is produced.
//  FSM states: IDLE, REQ, WAIT, DONE (lsu_state_t).
//  IDLE: on req_valid, latch all req_* fields. Misaligned if HALF with addr[0]=1,
//   or WORD with addr[1:0]!=0. Misaligned -> misaligned=1 next cycle, stay IDLE.
//   Otherwise -> REQ.
//  REQ: mem_req_valid=1. addr/we/be/wdata stay stable until mem_req_ready.
//   On handshake: store -> DONE; load -> WAIT. mem_rsp_valid seen in REQ is ignored.
//  WAIT: on mem_rsp_valid, capture aligned data into rsp_data -> DONE.
//  DONE: rsp_valid=1 for exactly one cycle -> IDLE.
//   rsp_data holds until the next load completes; a store leaves it unchanged.
//  busy=1 in REQ/WAIT/DONE and in the misaligned-flag cycle. req_valid is ignored
//   while busy; the core holds the op stalled.
//  Timeout: counter clears on entering REQ and increments in REQ/WAIT. When it
//   reaches TIMEOUT_CYCLES-1 with no progress: bus_error=1 next cycle, -> IDLE,
//   no rsp_valid, rsp_data unchanged.
//  Byte enables: BYTE 4'b0001<<a[1:0]; HALF 4'b0011<<{a[1],1'b0}; WORD 4'b1111.
//  Store data: BYTE {4{wd[7:0]}}; HALF {2{wd[15:0]}}; WORD wd.
//  Load align: shift rdata right by 8*a[1:0], take 8/16/32 LSBs, extend per sign.
//  Latency, zero-wait memory (ready in REQ, rsp one cycle later):
//   load: req at c0 -> REQ c1 -> WAIT c2 -> rsp_valid c3.
//   store: rsp_valid at c2.
// STRUCTURE
//  decoder_pkg: add mem_width_t {MEM_BYTE, MEM_HALF, MEM_WORD} and lsu_state_t;
//   reuse word.
//  Sub-module lsu_align (combinational): addr[1:0], width, sign, wdata, rdata
//   -> be, wdata_rep, rdata_ext, misaligned.
// TESTING
//  LW 0x100, ready c1, rdata 0xDEADBEEF at c2 -> rsp_valid c3, rsp_data 0xDEADBEEF.
//  LB signed 0x103, rdata 0x80xxxxxx -> rsp_data 0xFFFFFF80;
//   LBU -> 0x00000080; LH 0x102, rdata 0x8001xxxx -> 0xFFFF8001.
//  SB 0x101, wdata 0x000000AB -> mem_be 4'b0010, mem_wdata 0xABABABAB,
//   mem_we=1, rsp_valid 1 cycle after handshake.
//  LW 0x102 -> misaligned pulse, mem_req_valid never set; SH 0x101 likewise.
//  ready held 0 for 3 cycles -> request stable all 3 cycles; handshake proceeds normally.
//  ready never asserted, TIMEOUT_CYCLES=16 -> bus_error pulse, busy drops, no rsp_valid.
//  reset low during WAIT -> all outputs 0 asynchronously.
//   Release -> IDLE; a late mem_rsp_valid is ignored.

Source files
------------

// File: rtl/decoder_pkg.sv
// Shared datapath types for decode, execute and the load/store unit.
// Memory access widths and LSU transaction states live here.
package decoder_pkg;

  typedef logic [31:0] word;

  typedef enum logic [1:0] {
    MEM_BYTE = 2'd0,
    MEM_HALF = 2'd1,
    MEM_WORD = 2'd2
  } mem_width_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } lsu_state_t;

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering for the LSU: store enables/replication,
// load alignment with sign/zero extension, and alignment check.
module lsu_align
  import decoder_pkg::*;
(
  input  logic [1:0] addr_lo,
  input  mem_width_t width,
  input  logic       sign_ext,
  input  word        wdata,
  input  word        rdata,
  output logic [3:0] be,
  output word        wdata_rep,
  output word        rdata_ext,
  output logic       misaligned
);

  word sh;

  always_comb begin
    be         = 4'b0000;
    wdata_rep  = '0;
    rdata_ext  = '0;
    misaligned = 1'b0;
    sh         = rdata >> {addr_lo, 3'b000};
    unique case (width)
      MEM_BYTE: begin
        be        = 4'b0001 << addr_lo;
        wdata_rep = {4{wdata[7:0]}};
        rdata_ext = {{24{sign_ext & sh[7]}}, sh[7:0]};
      end
      MEM_HALF: begin
        be         = 4'b0011 << {addr_lo[1], 1'b0};
        wdata_rep  = {2{wdata[15:0]}};
        rdata_ext  = {{16{sign_ext & sh[15]}}, sh[15:0]};
        misaligned = addr_lo[0];
      end
      MEM_WORD: begin
        be         = 4'b1111;
        wdata_rep  = wdata;
        rdata_ext  = sh;
        misaligned = |addr_lo;
      end
      default: begin
        misaligned = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/lsu.sv
// Load/store unit: one outstanding op, valid/ready bus request,
// aligned load result for writeback, misalign and timeout flags.
module lsu
  import decoder_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req_valid,
  input  logic       req_we,
  input  mem_width_t req_width,
  input  logic       req_sign_ext,
  input  word        req_addr,
  input  word        req_wdata,
  output logic       busy,
  output logic       rsp_valid,
  output word        rsp_data,
  output logic       misaligned,
  output logic       bus_error,
  output logic       mem_req_valid,
  input  logic       mem_req_ready,
  output logic       mem_we,
  output word        mem_addr,
  output logic [3:0] mem_be,
  output word        mem_wdata,
  input  logic       mem_rsp_valid,
  input  word        mem_rsp_rdata
);

  localparam int CW = (TIMEOUT_CYCLES > 2) ?
                      $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX =
    CW'(TIMEOUT_CYCLES - 1);

  lsu_state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  mem_width_t width_q, width_d;
  logic sign_q, sign_d;
  logic [1:0] lo_q, lo_d;
  word mem_addr_q, mem_addr_d;
  logic [3:0] mem_be_q, mem_be_d;
  word mem_wdata_q, mem_wdata_d;
  logic mem_we_q, mem_we_d;
  word rsp_data_q, rsp_data_d;
  logic mis_q, mis_d;
  logic berr_q, berr_d;

  logic       idle;
  logic [1:0] al_lo;
  mem_width_t al_w;
  logic       al_sx;
  logic [3:0] al_be;
  word        al_wdata;
  word        al_rdata;
  logic       al_mis;
  logic       expired;

  // Decode live request fields in IDLE, latched ones afterwards.
  assign idle  = (state_q == IDLE);
  assign al_lo = idle ? req_addr[1:0] : lo_q;
  assign al_w  = idle ? req_width : width_q;
  assign al_sx = idle ? req_sign_ext : sign_q;

  lsu_align u_align (
    .addr_lo    (al_lo),
    .width      (al_w),
    .sign_ext   (al_sx),
    .wdata      (req_wdata),
    .rdata      (mem_rsp_rdata),
    .be         (al_be),
    .wdata_rep  (al_wdata),
    .rdata_ext  (al_rdata),
    .misaligned (al_mis)
  );

  assign expired = (cnt_q == CNT_MAX);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    width_d     = width_q;
    sign_d      = sign_q;
    lo_d        = lo_q;
    mem_addr_d  = mem_addr_q;
    mem_be_d    = mem_be_q;
    mem_wdata_d = mem_wdata_q;
    mem_we_d    = mem_we_q;
    rsp_data_d  = rsp_data_q;
    mis_d       = 1'b0;
    berr_d      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req_valid && !mis_q) begin
          width_d = req_width;
          sign_d  = req_sign_ext;
          lo_d    = req_addr[1:0];
          if (al_mis) begin
            mis_d = 1'b1;
          end else begin
            mem_addr_d  = {req_addr[31:2], 2'b00};
            mem_be_d    = al_be;
            mem_wdata_d = al_wdata;
            mem_we_d    = req_we;
            cnt_d       = '0;
            state_d     = REQ;
          end
        end
      end
      REQ: begin
        if (!expired) cnt_d = cnt_q + 1'b1;
        if (mem_req_ready) begin
          state_d = mem_we_q ? DONE : WAIT;
        end else if (expired) begin
          berr_d  = 1'b1;
          state_d = IDLE;
        end
      end
      WAIT: begin
        if (!expired) cnt_d = cnt_q + 1'b1;
        if (mem_rsp_valid) begin
          rsp_data_d = al_rdata;
          state_d    = DONE;
        end else if (expired) begin
          berr_d  = 1'b1;
          state_d = IDLE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      width_q     <= MEM_BYTE;
      sign_q      <= 1'b0;
      lo_q        <= 2'b00;
      mem_addr_q  <= '0;
      mem_be_q    <= 4'b0000;
      mem_wdata_q <= '0;
      mem_we_q    <= 1'b0;
      rsp_data_q  <= '0;
      mis_q       <= 1'b0;
      berr_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      width_q     <= width_d;
      sign_q      <= sign_d;
      lo_q        <= lo_d;
      mem_addr_q  <= mem_addr_d;
      mem_be_q    <= mem_be_d;
      mem_wdata_q <= mem_wdata_d;
      mem_we_q    <= mem_we_d;
      rsp_data_q  <= rsp_data_d;
      mis_q       <= mis_d;
      berr_q      <= berr_d;
    end
  end

  assign busy          = !idle || mis_q;
  assign rsp_valid     = (state_q == DONE);
  assign rsp_data      = rsp_data_q;
  assign misaligned    = mis_q;
  assign bus_error     = berr_q;
  assign mem_req_valid = (state_q == REQ);
  assign mem_we        = mem_we_q;
  assign mem_addr      = mem_addr_q;
  assign mem_be        = mem_be_q;
  assign mem_wdata     = mem_wdata_q;

endmodule

// File: tb/tb_lsu.sv
// Scoreboard bench for the load/store unit with a scripted memory.
// Expected events are queued at issue and matched at rsp/flag pulses.
module tb_lsu;
  import decoder_pkg::*;

  localparam logic [2:0] K_RSP  = 3'b100;
  localparam logic [2:0] K_MIS  = 3'b010;
  localparam logic [2:0] K_BERR = 3'b001;

  typedef struct {
    string      nm;
    logic [2:0] kind;
    word        data;
    int         cyc;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       req_valid = 1'b0;
  logic       req_we = 1'b0;
  mem_width_t req_width = MEM_WORD;
  logic       req_sign_ext = 1'b0;
  word        req_addr = '0;
  word        req_wdata = '0;
  logic       busy;
  logic       rsp_valid;
  word        rsp_data;
  logic       misaligned;
  logic       bus_error;
  logic       mem_req_valid;
  logic       mem_req_ready = 1'b0;
  logic       mem_we;
  word        mem_addr;
  logic [3:0] mem_be;
  word        mem_wdata;
  logic       mem_rsp_valid = 1'b0;
  word        mem_rsp_rdata = '0;

  exp_t sb[$];
  word  last = '0;
  int   cyc = 0;
  int   n_run = 0;
  int   n_fail = 0;

  lsu #(.TIMEOUT_CYCLES(16)) dut (
    .clk           (clk),
    .reset         (reset),
    .req_valid     (req_valid),
    .req_we        (req_we),
    .req_width     (req_width),
    .req_sign_ext  (req_sign_ext),
    .req_addr      (req_addr),
    .req_wdata     (req_wdata),
    .busy          (busy),
    .rsp_valid     (rsp_valid),
    .rsp_data      (rsp_data),
    .misaligned    (misaligned),
    .bus_error     (bus_error),
    .mem_req_valid (mem_req_valid),
    .mem_req_ready (mem_req_ready),
    .mem_we        (mem_we),
    .mem_addr      (mem_addr),
    .mem_be        (mem_be),
    .mem_wdata     (mem_wdata),
    .mem_rsp_valid (mem_rsp_valid),
    .mem_rsp_rdata (mem_rsp_rdata)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input word got, input word exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin : mon
    exp_t e;
    if (reset && (rsp_valid || misaligned || bus_error)) begin
      if (sb.size() == 0) begin
        chk("unexpected", 32'({rsp_valid, misaligned, bus_error}), 32'd0);
      end else begin
        e = sb.pop_front();
        chk({e.nm, ".kind"},
            32'({rsp_valid, misaligned, bus_error}), 32'(e.kind));
        chk({e.nm, ".data"}, rsp_data, e.data);
        chk({e.nm, ".cycle"}, 32'(cyc), 32'(e.cyc));
        chk({e.nm, ".busy"}, 32'(busy),
            (e.kind == K_BERR) ? 32'd0 : 32'd1);
      end
    end
  end

  task automatic issue(input logic we, input mem_width_t w,
                       input logic sx, input word a, input word wd);
    req_valid    = 1'b1;
    req_we       = we;
    req_width    = w;
    req_sign_ext = sx;
    req_addr     = a;
    req_wdata    = wd;
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic serve(input string nm, input logic ld, input int rd,
                       input int rl, input word rdata, input word ea,
                       input logic [3:0] ebe, input word ewd,
                       input logic ewe);
    for (int i = 0; i <= rd; i++) begin
      chk({nm, ".req_v"}, 32'(mem_req_valid), 32'd1);
      chk({nm, ".addr"}, mem_addr, ea);
      chk({nm, ".be"}, 32'(mem_be), 32'(ebe));
      chk({nm, ".wdata"}, mem_wdata, ewd);
      chk({nm, ".we"}, 32'(mem_we), 32'(ewe));
      mem_req_ready = (i == rd);
      mem_rsp_valid = ld && (rd > 0);
      mem_rsp_rdata = 32'h5555_5555;
      @(posedge clk); #1;
    end
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b0;
    if (ld) begin
      chk({nm, ".req_drop"}, 32'(mem_req_valid), 32'd0);
      repeat (rl) begin @(posedge clk); #1; end
      mem_rsp_valid = 1'b1;
      mem_rsp_rdata = rdata;
      @(posedge clk); #1;
      mem_rsp_valid = 1'b0;
      mem_rsp_rdata = '0;
    end
  endtask

  task automatic wait_idle(input string nm);
    int n = 0;
    while ((sb.size() != 0 || busy) && n < 60) begin
      @(posedge clk); #1;
      n++;
    end
    chk({nm, ".settle"}, 32'(n < 60), 32'd1);
    if (n >= 60) sb.delete();
  endtask

  task automatic op(input string nm, input logic we, input mem_width_t w,
                    input logic sx, input word a, input word wd,
                    input word rdata, input int rd, input int rl,
                    input word exp_d, input logic [3:0] ebe,
                    input word ewd);
    exp_t e;
    e.nm   = nm;
    e.kind = K_RSP;
    e.data = we ? last : exp_d;
    e.cyc  = cyc + (we ? 2 + rd : 3 + rd + rl);
    sb.push_back(e);
    if (!we) last = exp_d;
    issue(we, w, sx, a, wd);
    serve(nm, !we, rd, rl, rdata, {a[31:2], 2'b00}, ebe, ewd, we);
    wait_idle(nm);
  endtask

  task automatic mis_op(input string nm, input logic we,
                        input mem_width_t w, input word a);
    exp_t e;
    e.nm   = nm;
    e.kind = K_MIS;
    e.data = last;
    e.cyc  = cyc + 1;
    sb.push_back(e);
    issue(we, w, 1'b0, a, 32'h1234_5678);
    repeat (2) begin
      chk({nm, ".no_req"}, 32'(mem_req_valid), 32'd0);
      @(posedge clk); #1;
    end
    wait_idle(nm);
  endtask

  task automatic to_op(input string nm, input logic in_wait, input word a);
    exp_t e;
    e.nm   = nm;
    e.kind = K_BERR;
    e.data = last;
    e.cyc  = cyc + 17;
    sb.push_back(e);
    issue(1'b0, MEM_WORD, 1'b0, a, '0);
    if (in_wait) begin
      mem_req_ready = 1'b1;
      @(posedge clk); #1;
      mem_req_ready = 1'b0;
    end
    wait_idle(nm);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    #2;
    chk("rst.flags", 32'({busy, rsp_valid, misaligned, bus_error,
                          mem_req_valid, mem_we}), 32'd0);
    chk("rst.addr", mem_addr, 32'd0);
    chk("rst.be", 32'(mem_be), 32'd0);
    chk("rst.wdata", mem_wdata, 32'd0);
    chk("rst.rdata", rsp_data, 32'd0);
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;

    op("lw", 1'b0, MEM_WORD, 1'b0, 32'h100, '0, 32'hDEAD_BEEF,
       0, 0, 32'hDEAD_BEEF, 4'b1111, '0);
    op("lb", 1'b0, MEM_BYTE, 1'b1, 32'h103, '0, 32'h8012_3456,
       0, 0, 32'hFFFF_FF80, 4'b1000, '0);
    op("lbu", 1'b0, MEM_BYTE, 1'b0, 32'h103, '0, 32'h8012_3456,
       0, 0, 32'h0000_0080, 4'b1000, '0);
    op("lh", 1'b0, MEM_HALF, 1'b1, 32'h102, '0, 32'h8001_1234,
       0, 0, 32'hFFFF_8001, 4'b1100, '0);
    op("lhu", 1'b0, MEM_HALF, 1'b0, 32'h000, '0, 32'h1234_F00D,
       0, 0, 32'h0000_F00D, 4'b0011, '0);
    op("lb_pos", 1'b0, MEM_BYTE, 1'b1, 32'h001, '0, 32'h0000_7F00,
       0, 0, 32'h0000_007F, 4'b0010, '0);
    op("sb", 1'b1, MEM_BYTE, 1'b0, 32'h101, 32'h0000_00AB, '0,
       0, 0, '0, 4'b0010, 32'hABAB_ABAB);
    op("sh", 1'b1, MEM_HALF, 1'b0, 32'h102, 32'h1234_CAFE, '0,
       0, 0, '0, 4'b1100, 32'hCAFE_CAFE);
    op("sw_slow", 1'b1, MEM_WORD, 1'b0, 32'h200, 32'h0102_0304, '0,
       3, 0, '0, 4'b1111, 32'h0102_0304);
    op("lw_slow", 1'b0, MEM_WORD, 1'b0, 32'h104, '0, 32'hA5A5_0F0F,
       3, 2, 32'hA5A5_0F0F, 4'b1111, '0);

    mis_op("lw_mis", 1'b0, MEM_WORD, 32'h102);
    mis_op("sh_mis", 1'b1, MEM_HALF, 32'h101);
    mis_op("lh_mis", 1'b0, MEM_HALF, 32'h103);

    to_op("to_req", 1'b0, 32'h108);
    to_op("to_wait", 1'b1, 32'h10C);

    issue(1'b0, MEM_WORD, 1'b0, 32'h300, '0);
    mem_req_ready = 1'b1;
    @(posedge clk); #1;
    mem_req_ready = 1'b0;
    chk("rst_wait.busy", 32'(busy), 32'd1);
    #1 reset = 1'b0;
    #1;
    chk("rst_wait.flags", 32'({busy, rsp_valid, misaligned, bus_error,
                               mem_req_valid, mem_we}), 32'd0);
    chk("rst_wait.addr", mem_addr, 32'd0);
    chk("rst_wait.be", 32'(mem_be), 32'd0);
    chk("rst_wait.wdata", mem_wdata, 32'd0);
    chk("rst_wait.rdata", rsp_data, 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    last  = '0;
    mem_rsp_valid = 1'b1;
    mem_rsp_rdata = 32'hCAFE_F00D;
    @(posedge clk); #1;
    mem_rsp_valid = 1'b0;
    mem_rsp_rdata = '0;
    repeat (3) begin @(posedge clk); #1; end
    chk("late_rsp.busy", 32'(busy), 32'd0);
    chk("late_rsp.rdata", rsp_data, 32'd0);

    op("lbu_post", 1'b0, MEM_BYTE, 1'b0, 32'h101, '0, 32'h0000_AB00,
       0, 0, 32'h0000_00AB, 4'b0010, '0);

    chk("sb_drain", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
